// File: rtl/icache_fill_fsm_if.sv
// Fetch-side miss request, memory read/return channel and cache array write port
// for the instruction cache block-fill controller.
interface icache_fill_fsm_if #(
  parameter int SEL_W = 3
);
  logic             miss_detected;
  logic [15:0]      miss_address;
  logic             memory_data_valid;
  logic [15:0]      memory_data;
  logic             fsm_busy;
  logic             mem_read_en;
  logic [15:0]      memory_address;
  logic             write_data_array;
  logic [SEL_W-1:0] data_word_sel;
  logic [15:0]      cache_write_data;
  logic             write_tag_array;
  logic [15:0]      fill_address;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address, write_data_array,
           data_word_sel, cache_write_data, write_tag_array, fill_address
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address, write_data_array,
           data_word_sel, cache_write_data, write_tag_array, fill_address
  );
endinterface

// File: rtl/icache_fill_fsm.sv
// Instruction cache miss-service FSM: issues the block's word reads back to back,
// writes returned words into the data array in order, then writes the tag.
//
//   state | meaning
//   IDLE  | no fill; waiting for miss_detected
//   FILL  | issuing reads and accepting returned words for the block at base
module icache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int OFFSET_W        = 4,
  parameter int MAX_LATENCY     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  icache_fill_fsm_if.master bus
);
  localparam int SEL_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = SEL_W + 1;
  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [SEL_W-1:0] RECV_LAST = SEL_W'(WORDS_PER_BLOCK - 1);

  if ((WORDS_PER_BLOCK < 2) || ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) ||
      (OFFSET_W != SEL_W + 1) || (MAX_LATENCY < 1)) begin : g_param_check
    $error("icache_fill_fsm: inconsistent block geometry parameters");
  end

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] issue_cnt;
  logic [SEL_W-1:0] recv_cnt;
  logic [15:0]      base;
  logic             issue_active;

  assign issue_active         = (state == FILL) && (issue_cnt < ISSUE_END);
  assign bus.cache_write_data = bus.memory_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (bus.miss_detected) begin
          base      <= {bus.miss_address[15:OFFSET_W], {OFFSET_W{1'b0}}};
          issue_cnt <= '0;
          recv_cnt  <= '0;
        end
      end else begin
        if (issue_active) issue_cnt <= issue_cnt + CNT_W'(1);
        if (bus.memory_data_valid) recv_cnt <= recv_cnt + SEL_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt            = state;
    bus.fsm_busy         = 1'b0;
    bus.mem_read_en      = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.data_word_sel    = '0;
    bus.write_tag_array  = 1'b0;
    bus.fill_address     = '0;
    case (state)
      IDLE: begin
        if (bus.miss_detected) state_nxt = FILL;
      end
      FILL: begin
        bus.fsm_busy     = 1'b1;
        bus.fill_address = base;
        if (issue_active) begin
          bus.mem_read_en    = 1'b1;
          // base is block aligned, so the word offset never carries into the index/tag
          bus.memory_address = base + 16'({issue_cnt[SEL_W-1:0], 1'b0});
        end
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.data_word_sel    = recv_cnt;
          if (recv_cnt == RECV_LAST) begin
            bus.write_tag_array = 1'b1;
            state_nxt           = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_icache_fill_fsm.sv
// Directed bench for icache_fill_fsm: drives miss/return sequences cycle by cycle and
// compares every output against hand-computed values.
module tb_icache_fill_fsm;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  icache_fill_fsm_if #(.SEL_W(3)) bus ();

  icache_fill_fsm #(
    .WORDS_PER_BLOCK(8),
    .OFFSET_W(4),
    .MAX_LATENCY(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic miss, input logic [15:0] maddr,
                       input logic vld, input logic [15:0] data);
    bus.miss_detected     = miss;
    bus.miss_address      = maddr;
    bus.memory_data_valid = vld;
    bus.memory_data       = data;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic busy, input logic rd,
                           input logic [15:0] addr, input logic wda, input logic [2:0] sel,
                           input logic tagw, input logic [15:0] fill);
    check({tag, ".busy"}, 32'(bus.fsm_busy), 32'(busy));
    check({tag, ".rd"},   32'(bus.mem_read_en), 32'(rd));
    check({tag, ".addr"}, 32'(bus.memory_address), 32'(addr));
    check({tag, ".wda"},  32'(bus.write_data_array), 32'(wda));
    check({tag, ".sel"},  32'(bus.data_word_sel), 32'(sel));
    check({tag, ".tag"},  32'(bus.write_tag_array), 32'(tagw));
    check({tag, ".fill"}, 32'(bus.fill_address), 32'(fill));
    check({tag, ".cwd"},  32'(bus.cache_write_data), 32'(bus.memory_data));
  endtask

  initial begin
    int pat[12] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    int recv;
    logic v;

    // reset held with miss and valid asserted
    rst_n = 1'b0;
    drive(1'b1, 16'h1236, 1'b1, 16'hBEEF);
    tick();
    tick();
    drive(1'b1, 16'h1236, 1'b1, 16'hBEEF);
    check_all("rst", 0, 0, 16'h0, 0, 3'd0, 0, 16'h0);
    rst_n = 1'b1;
    drive(1'b1, 16'h1236, 1'b0, 16'h0);
    check_all("rel", 0, 0, 16'h0, 0, 3'd0, 0, 16'h0);
    tick();

    // miss at 0x1236, fixed 4-cycle return latency
    for (int c = 0; c < 12; c++) begin
      v = (c >= 4);
      drive(1'b0, 16'h1236, v, 16'hA000 + 16'(c));
      check_all($sformatf("lat4[%0d]", c), 1, (c < 8),
                (c < 8) ? 16'h1230 + 16'(2 * c) : 16'h0,
                v, v ? 3'(c - 4) : 3'd0, (c == 11), 16'h1230);
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    check_all("lat4.done", 0, 0, 16'h0, 0, 3'd0, 0, 16'h0);

    // irregular return pattern, miss at 0x2008
    drive(1'b1, 16'h2008, 1'b0, 16'h0);
    check({"irr.idle", ".busy"}, 32'(bus.fsm_busy), 32'd0);
    tick();
    recv = 0;
    for (int c = 0; c < 12; c++) begin
      v = (pat[c] != 0);
      drive(1'b0, 16'h0, v, 16'h5000 + 16'(c));
      check_all($sformatf("irr[%0d]", c), 1, (c < 8),
                (c < 8) ? 16'h2000 + 16'(2 * c) : 16'h0,
                v, v ? 3'(recv) : 3'd0, v && (recv == 7), 16'h2000);
      if (v) recv++;
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    check_all("irr.done", 0, 0, 16'h0, 0, 3'd0, 0, 16'h0);

    // top-of-memory block, mid-fill miss ignored
    drive(1'b1, 16'hFFFA, 1'b0, 16'h0);
    tick();
    for (int c = 0; c < 9; c++) begin
      v = (c >= 1);
      drive((c == 3), (c == 3) ? 16'h5555 : 16'hFFFA, v, 16'hC000 + 16'(c));
      check_all($sformatf("top[%0d]", c), 1, (c < 8),
                (c < 8) ? 16'hFFF0 + 16'(2 * c) : 16'h0,
                v, v ? 3'(c - 1) : 3'd0, (c == 8), 16'hFFF0);
      tick();
    end

    // back-to-back miss right after completion
    drive(1'b1, 16'h0040, 1'b0, 16'h0);
    check_all("b2b.idle", 0, 0, 16'h0, 0, 3'd0, 0, 16'h0);
    tick();
    for (int c = 0; c < 4; c++) begin
      v = (c >= 1);
      if (c == 3) rst_n = 1'b0;
      drive(1'b0, 16'h0, v, 16'hD000 + 16'(c));
      check_all($sformatf("b2b[%0d]", c), 1, 1, 16'h0040 + 16'(2 * c),
                v, v ? 3'(c - 1) : 3'd0, 0, 16'h0040);
      tick();
    end
    rst_n = 1'b1;

    // after mid-fill reset, and valids in IDLE, nothing is written
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 16'h0, 1'b1, 16'hE000 + 16'(c));
      check_all($sformatf("idlev[%0d]", c), 0, 0, 16'h0, 0, 3'd0, 0, 16'h0);
      tick();
    end

    // new fill starts from word 0
    drive(1'b1, 16'h0104, 1'b0, 16'h0);
    tick();
    drive(1'b0, 16'h0, 1'b1, 16'h7777);
    check_all("fresh", 1, 1, 16'h0100, 1, 3'd0, 0, 16'h0100);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/icache_fill_fsm.md
Name: icache_fill_fsm

Overview:
- Miss-service responder for the instruction fetch path.
- When the instruction cache reports a miss on a fetch address, it fetches the whole 16-byte block from the multicycle pipelined main memory.
- It writes each returned word into the cache data array, then writes the tag.
- It holds fsm_busy high for the whole fill; fetch treats fsm_busy as a stall.

Parameters:
- WORDS_PER_BLOCK, 8, number of 16-bit words per cache block. Must be a power of 2. Block size in bytes is 2*WORDS_PER_BLOCK.
- OFFSET_W, 4, byte-offset bits per block. Equals log2(2*WORDS_PER_BLOCK).
- MAX_LATENCY, 4, upper bound on memory read latency in cycles. Used only for bench checking; RTL does not depend on it.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset: one clock; synchronous, active-low.
- miss_detected  in  1  cache miss on the current fetch. Sampled only in IDLE.
- miss_address  in  16  byte address of the missing fetch.
- memory_data_valid  in  1  memory_data holds the next returned word, in issue order.
- memory_data  in  16  word returned by main memory.
- fsm_busy  out  1  fill in progress; stalls fetch.
- mem_read_en  out  1  issue a read of memory_address this cycle.
- memory_address  out  16  word address being issued.
- write_data_array  out  1  write cache_write_data into word data_word_sel of the block.
- data_word_sel  out  3  word index within the block, log2(WORDS_PER_BLOCK) bits.
- cache_write_data  out  16  combinational pass-through of memory_data.
- write_tag_array  out  1  one-cycle pulse: write tag/valid for the filled block.
- fill_address  out  16  block base address, for tag/index generation.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; issue_cnt, recv_cnt and base go to 0.
  - All outputs read 0 from the next cycle: fsm_busy, mem_read_en, write_data_array, write_tag_array, memory_address, data_word_sel, fill_address. cache_write_data remains a pass-through.
  - Reset mid-fill aborts immediately. No further reads, data writes or tag write occur.
- States: IDLE, FILL.
- IDLE:
  - fsm_busy=0 and mem_read_en=0.
  - memory_data_valid is ignored: write_data_array stays 0.
  - miss_detected=1 at an edge latches base={miss_address[15:OFFSET_W], OFFSET_W'b0}, clears both counters and moves to FILL.
- FILL, issue side:
  - fsm_busy=1.
  - mem_read_en=1 while issue_cnt<WORDS_PER_BLOCK.
  - memory_address=base+2*issue_cnt. issue_cnt increments each cycle mem_read_en=1.
  - The 8 reads issue in 8 consecutive cycles, starting the first FILL cycle.
  - After the 8th read: mem_read_en=0 and memory_address=0.
- FILL, receive side:
  - Each cycle with memory_data_valid=1: write_data_array=1 and data_word_sel=recv_cnt. recv_cnt increments.
  - Valid may arrive with any gaps, including in the same cycle as an issue. Data is assumed in order.
- Completion:
  - The cycle the 8th valid is accepted (recv_cnt==7 and valid): write_tag_array=1, in the same cycle as the final data write.
  - Next state is IDLE, so fsm_busy falls the following cycle.
- fill_address=base in FILL, 0 in IDLE.
- miss_detected during FILL is ignored. A miss asserted in the IDLE cycle right after completion starts a new fill; there is no dead cycle requirement.
- Extra valids after the 8th are ignored, since the state is already IDLE.
- Address arithmetic is 16-bit; base is block-aligned, so base+14 never carries out.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles while driving miss_detected=1 and memory_data_valid=1 -> all outputs 0. Release rst_n -> fill starts on the following edge.
2. Miss at 0x1236, memory returns data 4 cycles after each issue:
   - memory_address=0x1230,0x1232,...,0x123E on 8 consecutive cycles with mem_read_en=1.
   - write_data_array pulses with data_word_sel 0..7 and cache_write_data equal to the driven words.
   - write_tag_array pulses once, with the sel=7 write.
   - fsm_busy high for 12 cycles; fill_address=0x1230.
3. Irregular return: valid pattern 1,0,0,1,1,0,1,1,1,0,1,1 -> exactly 8 data writes with sel 0..7 in order. Tag written on the 8th valid; fsm_busy drops the cycle after.
4. Miss at 0xFFFA -> addresses 0xFFF0..0xFFFE with no wrap or overflow. A second miss_detected=1 asserted mid-fill is ignored. A miss at 0x0040 on the cycle after completion starts a new fill at base 0x0040.
5. Reset at cycle 3 of a fill -> next cycle IDLE. No write_tag_array pulse. Later valids produce no data writes.
6. memory_data_valid=1 for 5 cycles in IDLE -> write_data_array and write_tag_array stay 0; state stays IDLE.
